// File: rtl/conv_window_mem.sv
// -----------------------------------------------------------------------------
// conv_window_mem
//
// Holds one NxN input matrix and one KxK filter for the convolution engine.
// Both memories are loaded through a single auto-addressed beat interface.
// A small fetch FSM then streams one KxK window of the matrix, one row per
// beat, over a valid/ready handshake. Each beat carries the matching filter row.
//
// Optional feature (compile-time macro ZERO_PAD_EN):
//   defined   - any origin is accepted; matrix elements whose row or column
//               falls outside the matrix read as 0 (filter data unaffected)
//   undefined - the window must fit entirely inside the matrix; otherwise the
//               request is rejected with a one-cycle err pulse
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   data_w              load data word
//   ld_valid/ld_ready   load beat handshake (ld_ready = !busy)
//   ld_tgt              0 = matrix, 1 = filter
//   ld_clr              zero both load pointers and clear both full flags
//   mat_full, fil_full  every word of that memory written since the last clear
//   win_start           single-cycle request to fetch a window
//   win_row, win_col    window origin (top-left element)
//   busy                fetch in progress
//   win_valid/win_ready window beat handshake
//   win_data            matrix row slice, element j in bits [j*DW +: DW]
//   fil_data            filter row aligned with win_data
//   win_last            marks the K-th beat
//   done                one-cycle pulse after the last beat is accepted
//   err                 one-cycle pulse on a rejected origin
// -----------------------------------------------------------------------------
module conv_window_mem #(
    parameter int DW = 8,
    parameter int N  = 4,
    parameter int K  = 3,
    parameter int AW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   data_w,
    input  logic            ld_valid,
    input  logic            ld_tgt,
    input  logic            ld_clr,
    output logic            ld_ready,
    output logic            mat_full,
    output logic            fil_full,
    input  logic            win_start,
    input  logic [AW-1:0]   win_row,
    input  logic [AW-1:0]   win_col,
    output logic            busy,
    output logic            win_valid,
    input  logic            win_ready,
    output logic [K*DW-1:0] win_data,
    output logic [K*DW-1:0] fil_data,
    output logic            win_last,
    output logic            done,
    output logic            err
);

    localparam int MW  = N * N;
    localparam int FW  = K * K;
    localparam int MPW = (MW > 1) ? $clog2(MW) : 1;
    localparam int FPW = (FW > 1) ? $clog2(FW) : 1;
    localparam int RW  = (K > 1) ? $clog2(K) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FETCH = 1'b1;

    logic [DW-1:0]  mat_mem [MW];
    logic [DW-1:0]  fil_mem [FW];
    logic [MPW-1:0] mat_ptr;
    logic [FPW-1:0] fil_ptr;

    logic [0:0]     state;
    logic [AW-1:0]  row0;
    logic [AW-1:0]  col0;
    logic [RW-1:0]  r;

    logic           ld_write;
    logic           origin_ok;
    logic           last_beat;

    int             sel_row;
    int             sel_col;
    int             sel_r;
    logic [K*DW-1:0] next_win;
    logic [K*DW-1:0] next_fil;

    assign busy      = (state == FETCH);
    assign ld_ready  = !busy;
    // ld_clr wins over a same-cycle beat: the beat is dropped, not written.
    assign ld_write  = ld_valid && ld_ready && !ld_clr;
    assign last_beat = (int'(r) == K - 1);

`ifdef ZERO_PAD_EN
    // Out-of-matrix elements are zero-filled, so every origin is legal.
    assign origin_ok = 1'b1;
`else
    assign origin_ok = (int'(win_row) <= N - K) && (int'(win_col) <= N - K);
`endif

    // Row that the next registered beat should carry: the first row when a
    // fetch is being launched, otherwise the row after the current one.
    always_comb begin
        sel_row = 0;
        sel_col = 0;
        sel_r   = 0;
        if (state == IDLE) begin
            sel_row = int'(win_row);
            sel_col = int'(win_col);
            sel_r   = 0;
        end else begin
            sel_r   = int'(r) + 1;
            sel_row = int'(row0) + sel_r;
            sel_col = int'(col0);
        end
    end

    // Index arithmetic is done in int so that a padded window running past
    // the matrix edge does not wrap back into the matrix. Without padding
    // the range tests are always true for an accepted origin.
    always_comb begin
        next_win = '0;
        next_fil = '0;
        for (int j = 0; j < K; j++) begin
            if (sel_row < N && (sel_col + j) < N) begin
                next_win[j*DW +: DW] = mat_mem[MPW'(sel_row * N + sel_col + j)];
            end
            if (sel_r < K) begin
                next_fil[j*DW +: DW] = fil_mem[FPW'(sel_r * K + j)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the memories are cleared on reset because a fetch after
            // reset must read zeros; plain storage would normally be left
            // unreset so it can map onto RAM.
            for (int i = 0; i < MW; i++) begin
                mat_mem[i] <= '0;
            end
            for (int i = 0; i < FW; i++) begin
                fil_mem[i] <= '0;
            end
            mat_ptr   <= '0;
            fil_ptr   <= '0;
            mat_full  <= 1'b0;
            fil_full  <= 1'b0;
            state     <= IDLE;
            row0      <= '0;
            col0      <= '0;
            r         <= '0;
            win_valid <= 1'b0;
            win_data  <= '0;
            fil_data  <= '0;
            win_last  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            // ---------------- load path ----------------
            if (ld_clr) begin
                mat_ptr  <= '0;
                fil_ptr  <= '0;
                mat_full <= 1'b0;
                fil_full <= 1'b0;
            end else if (ld_write) begin
                if (!ld_tgt) begin
                    mat_mem[mat_ptr] <= data_w;
                    if (int'(mat_ptr) == MW - 1) begin
                        mat_ptr  <= '0;
                        mat_full <= 1'b1;
                    end else begin
                        mat_ptr <= mat_ptr + 1'b1;
                    end
                end else begin
                    fil_mem[fil_ptr] <= data_w;
                    if (int'(fil_ptr) == FW - 1) begin
                        fil_ptr  <= '0;
                        fil_full <= 1'b1;
                    end else begin
                        fil_ptr <= fil_ptr + 1'b1;
                    end
                end
            end

            // ---------------- window fetch ----------------
            case (state)
                IDLE: begin
                    if (win_start) begin
                        if (origin_ok) begin
                            row0      <= win_row;
                            col0      <= win_col;
                            r         <= '0;
                            win_valid <= 1'b1;
                            win_data  <= next_win;
                            fil_data  <= next_fil;
                            win_last  <= (K == 1);
                            state     <= FETCH;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    // Outputs only move on an accepted beat, so a stalled
                    // beat holds its data.
                    if (win_ready) begin
                        if (last_beat) begin
                            win_valid <= 1'b0;
                            win_last  <= 1'b0;
                            win_data  <= '0;
                            fil_data  <= '0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            r         <= r + 1'b1;
                            win_data  <= next_win;
                            fil_data  <= next_fil;
                            win_last  <= (int'(r) + 2 == K);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    win_valid <= 1'b0;
                    win_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule
